// File: rtl/seg_scan_display.sv
// Multiplexed seven-segment countdown driver: sequential binary-to-BCD conversion,
// leading-zero blanking, per-direction flag glyphs, low-time blink and guarded anode scan.
module seg_scan_display #(
    parameter int NUM_DIGITS   = 4,
    parameter int TIME_DIGITS  = 2,
    parameter int TIME_WIDTH   = 7,
    parameter int SCAN_DIV     = 50000,
    parameter int BLINK_DIV    = 25000000,
    parameter int BLINK_THRESH = 5
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic [TIME_WIDTH-1:0]            time_in,
    input  logic                             time_load,
    input  logic [NUM_DIGITS-TIME_DIGITS-1:0] flag,
    input  logic                             blink_en,
    output logic [7:0]                       oSeg,
    output logic [NUM_DIGITS-1:0]            oAn,
    output logic                             flicker,
    output logic                             busy
);

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_SHIFT = 1'b1;

    localparam int IW = $clog2(TIME_WIDTH + 1);
    localparam int SW = $clog2(SCAN_DIV);
    localparam int BW = $clog2(BLINK_DIV + 1);
    localparam int XW = $clog2(NUM_DIGITS);
    localparam logic [31:0] SAT_VAL = 32'(10**TIME_DIGITS - 1);
    localparam logic [31:0] THRESH  = 32'(BLINK_THRESH);

    logic [0:0]                       state;
    logic [TIME_WIDTH-1:0]            shiftReg, srcBin, pendVal, dispBin;
    logic                             pendValid;
    logic [IW-1:0]                    iterCnt;
    logic [TIME_DIGITS-1:0][3:0]      workBcd, adjBcd, nextBcd, dispBcd;
    logic [TIME_WIDTH-1:0]            nextShift;
    logic [TIME_DIGITS*4+TIME_WIDTH-1:0] shiftCat;
    logic                             lastIter;

    logic [SW-1:0]                    slot, slotNext;
    logic [XW-1:0]                    idx, idxNext;
    logic [BW-1:0]                    blinkCnt;
    logic                             phase;
    logic [NUM_DIGITS-1:0][7:0]       glyph;

    function automatic logic [7:0] seg7(input logic [3:0] v);
        case (v)
            4'd0: seg7 = 8'hC0;
            4'd1: seg7 = 8'hF9;
            4'd2: seg7 = 8'hA4;
            4'd3: seg7 = 8'hB0;
            4'd4: seg7 = 8'h99;
            4'd5: seg7 = 8'h92;
            4'd6: seg7 = 8'h82;
            4'd7: seg7 = 8'hF8;
            4'd8: seg7 = 8'h80;
            4'd9: seg7 = 8'h90;
            default: seg7 = 8'hFF;
        endcase
    endfunction

    // Double-dabble step; digits above TIME_DIGITS are dropped, overflow is caught by comparison.
    always_comb begin
        for (int d = 0; d < TIME_DIGITS; d++)
            adjBcd[d] = (workBcd[d] >= 4'd5) ? workBcd[d] + 4'd3 : workBcd[d];
        shiftCat  = {adjBcd, shiftReg} << 1;
        nextBcd   = shiftCat[TIME_DIGITS*4+TIME_WIDTH-1:TIME_WIDTH];
        nextShift = shiftCat[TIME_WIDTH-1:0];
        lastIter  = (iterCnt == IW'(TIME_WIDTH - 1));
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            busy      <= 1'b0;
            shiftReg  <= '0;
            srcBin    <= '0;
            workBcd   <= '0;
            iterCnt   <= '0;
            pendVal   <= '0;
            pendValid <= 1'b0;
            dispBcd   <= '0;
            dispBin   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (time_load) begin
                        shiftReg <= time_in;
                        srcBin   <= time_in;
                        workBcd  <= '0;
                        iterCnt  <= '0;
                        state    <= ST_SHIFT;
                        busy     <= 1'b1;
                    end
                end
                default: begin
                    shiftReg <= nextShift;
                    workBcd  <= nextBcd;
                    iterCnt  <= iterCnt + IW'(1);
                    if (time_load) begin
                        pendVal   <= time_in;
                        pendValid <= 1'b1;
                    end
                    if (lastIter) begin
                        if (32'(srcBin) > SAT_VAL) begin
                            dispBcd <= {TIME_DIGITS{4'd9}};
                            dispBin <= SAT_VAL[TIME_WIDTH-1:0];
                        end else begin
                            dispBcd <= nextBcd;
                            dispBin <= srcBin;
                        end
                        // A load landing on the completion edge is newer than anything pending.
                        if (time_load || pendValid) begin
                            shiftReg  <= time_load ? time_in : pendVal;
                            srcBin    <= time_load ? time_in : pendVal;
                            workBcd   <= '0;
                            iterCnt   <= '0;
                            pendValid <= 1'b0;
                        end else begin
                            state <= ST_IDLE;
                            busy  <= 1'b0;
                        end
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            blinkCnt <= '0;
            phase    <= 1'b0;
            flicker  <= 1'b0;
        end else begin
            if (blinkCnt == BW'(BLINK_DIV - 1)) begin
                blinkCnt <= '0;
                phase    <= ~phase;
            end else begin
                blinkCnt <= blinkCnt + BW'(1);
            end
            flicker <= blink_en && (32'(dispBin) <= THRESH);
        end
    end

    always_comb begin
        logic zeroAbove;
        glyph     = '1;
        zeroAbove = 1'b1;
        for (int d = TIME_DIGITS - 1; d >= 0; d--) begin
            zeroAbove = zeroAbove && (dispBcd[d] == 4'd0);
            if ((flicker && phase) || (d != 0 && zeroAbove))
                glyph[d] = 8'hFF;
            else
                glyph[d] = seg7(dispBcd[d]);
        end
        for (int f = 0; f < NUM_DIGITS - TIME_DIGITS; f++)
            glyph[TIME_DIGITS + f] = flag[f] ? 8'hBF : 8'hFF;
    end

    // Outputs are registered from the post-edge slot/index so digit 0 lights on the first edge.
    always_comb begin
        slotNext = (slot == SW'(SCAN_DIV - 1)) ? '0 : slot + SW'(1);
        idxNext  = idx;
        if (slot == SW'(SCAN_DIV - 1))
            idxNext = (idx == XW'(NUM_DIGITS - 1)) ? '0 : idx + XW'(1);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            slot <= '0;
            idx  <= '0;
            oAn  <= '1;
            oSeg <= 8'hFF;
        end else begin
            slot <= slotNext;
            idx  <= idxNext;
            if (slotNext == '0) begin
                oAn  <= '1;
                oSeg <= 8'hFF;
            end else begin
                oAn  <= ~(NUM_DIGITS'(1) << idxNext);
                oSeg <= glyph[idxNext];
            end
        end
    end

endmodule

// File: tb/tb_seg_scan_display.sv
// Bench for seg_scan_display: directed plus random loads, checked against an arithmetic
// model of the scan position, blink phase and decimal glyphs.
module tb_seg_scan_display;

    localparam int ND = 4, TD = 2, TW = 7, SD = 4, BD = 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [TW-1:0] time_in;
    logic          time_load;
    logic [1:0]    flag;
    logic          blink_en;
    logic [7:0]    oSeg;
    logic [ND-1:0] oAn;
    logic          flicker, busy;

    int nChecks = 0;
    int nPass   = 0;
    int edgeCnt = 0;

    seg_scan_display #(
        .NUM_DIGITS(ND), .TIME_DIGITS(TD), .TIME_WIDTH(TW),
        .SCAN_DIV(SD), .BLINK_DIV(BD), .BLINK_THRESH(5)
    ) dut (
        .clk(clk), .rst_n(rst_n), .time_in(time_in), .time_load(time_load),
        .flag(flag), .blink_en(blink_en), .oSeg(oSeg), .oAn(oAn),
        .flicker(flicker), .busy(busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (!rst_n) edgeCnt <= 0;
        else        edgeCnt <= edgeCnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nChecks++;
        assert (obs === exp) nPass++;
        else $error("FAIL %s: observed %0h expected %0h (edge %0d)", tag, obs, exp, edgeCnt);
    endtask

    function automatic logic [7:0] digitGlyph(input int d);
        case (d)
            0: return 8'hC0; 1: return 8'hF9; 2: return 8'hA4; 3: return 8'hB0;
            4: return 8'h99; 5: return 8'h92; 6: return 8'h82; 7: return 8'hF8;
            8: return 8'h80; default: return 8'h90;
        endcase
    endfunction

    // Expected outputs registered at edge n since reset release, for a settled display value.
    function automatic logic [7:0] expSeg(input int n, input int val, input logic [1:0] flg,
                                          input logic bEn);
        int v, slotN, idxN;
        logic blank;
        v     = (val > 99) ? 99 : val;
        slotN = n % SD;
        idxN  = (n / SD) % ND;
        blank = bEn && (v <= 5) && (((n - 1) / BD) % 2 == 1);
        if (slotN == 0) return 8'hFF;
        if (idxN == 0)  return blank ? 8'hFF : digitGlyph(v % 10);
        if (idxN == 1)  return (blank || v < 10) ? 8'hFF : digitGlyph(v / 10);
        return flg[idxN-2] ? 8'hBF : 8'hFF;
    endfunction

    function automatic logic [ND-1:0] expAn(input int n);
        logic [ND-1:0] one;
        one = 1;
        if (n % SD == 0) return '1;
        return ~(one << ((n / SD) % ND));
    endfunction

    task automatic scanCheck(input string tag, input int cycles, input int val,
                             input logic [1:0] flg, input logic bEn);
        int v;
        v = (val > 99) ? 99 : val;
        for (int i = 0; i < cycles; i++) begin
            check({tag, "_an"},  oAn,  expAn(edgeCnt));
            check({tag, "_seg"}, oSeg, expSeg(edgeCnt, val, flg, bEn));
            check({tag, "_flk"}, flicker, bEn && (v <= 5));
            check({tag, "_busy"}, busy, 1'b0);
            @(negedge clk);
        end
    endtask

    task automatic loadVal(input int v);
        @(negedge clk);
        time_in   = TW'(v);
        time_load = 1'b1;
        @(negedge clk);
        time_load = 1'b0;
    endtask

    task automatic waitIdle(input string tag);
        int k;
        k = 0;
        while (busy && k < 50) begin
            @(negedge clk);
            k++;
        end
        check({tag, "_idle_timeout"}, busy, 1'b0);
        repeat (2) @(negedge clk);
    endtask

    initial begin
        int busyCnt, busyRun, val;
        logic seenLow, rerise;
        logic [1:0] rf;
        logic rb;

        rst_n = 1'b0; time_in = '0; time_load = 1'b0; flag = 2'b00; blink_en = 1'b0;

        // Reset, then the scan pattern with the cleared (zero) display.
        repeat (3) @(negedge clk);
        check("rst_an", oAn, 4'hF);
        check("rst_seg", oSeg, 8'hFF);
        check("rst_busy", busy, 1'b0);
        check("rst_flk", flicker, 1'b0);
        rst_n = 1'b1;
        @(negedge clk);
        scanCheck("scan0", 32, 0, 2'b00, 1'b0);

        // Load 42: busy for exactly TIME_WIDTH cycles.
        loadVal(42);
        busyCnt = 0;
        while (busy && busyCnt < 40) begin
            busyCnt++;
            @(negedge clk);
        end
        check("conv42_busylen", busyCnt, 7);
        repeat (2) @(negedge clk);
        scanCheck("conv42", 16, 42, 2'b00, 1'b0);

        // Load 7 with blinking enabled: flicker and alternate-phase blanking.
        blink_en = 1'b1;
        loadVal(7);
        waitIdle("ld7");
        scanCheck("ld7", 40, 7, 2'b00, 1'b1);

        // Saturation and flag glyphs.
        flag = 2'b10;
        loadVal(120);
        waitIdle("sat");
        scanCheck("sat", 16, 120, 2'b10, 1'b1);

        // Back-to-back: 30, then 15 and 60 while busy; only 60 follows 30.
        blink_en = 1'b0;
        flag     = 2'b00;
        @(negedge clk);
        time_in = TW'(30); time_load = 1'b1;
        busyRun = 0; seenLow = 1'b0; rerise = 1'b0;
        for (int c = 1; c < 40; c++) begin
            @(negedge clk);
            time_load = (c == 2 || c == 4);
            time_in   = (c == 2) ? TW'(15) : TW'(60);
            if (busy) begin
                if (seenLow) rerise = 1'b1;
                else         busyRun++;
            end else begin
                seenLow = 1'b1;
            end
        end
        check("b2b_busylen_ok", (busyRun >= 14 && busyRun <= 15), 1'b1);
        check("b2b_no_extra_conv", rerise, 1'b0);
        scanCheck("b2b", 16, 60, 2'b00, 1'b0);

        // Reset mid-conversion discards the in-flight value.
        loadVal(88);
        repeat (2) @(negedge clk);
        check("mid_busy_pre", busy, 1'b1);
        rst_n = 1'b0;
        @(negedge clk);
        check("mid_rst_busy", busy, 1'b0);
        check("mid_rst_an", oAn, 4'hF);
        check("mid_rst_seg", oSeg, 8'hFF);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        scanCheck("mid_after", 32, 0, 2'b00, 1'b0);

        // Random loads, small values favoured on odd passes to exercise blinking.
        for (int r = 0; r < 10; r++) begin
            val = (r % 2 == 1) ? int'($urandom_range(0, 9)) : int'($urandom_range(0, 127));
            rf  = 2'($urandom_range(0, 3));
            rb  = 1'($urandom_range(0, 1));
            @(negedge clk);
            flag = rf; blink_en = rb;
            loadVal(val);
            waitIdle("rnd");
            scanCheck("rnd", 20, val, rf, rb);
        end

        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule
